// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU select codes, FSM states, widths.
package alu_share_arbiter_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int SEL_W      = 4;

  localparam logic [SEL_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [SEL_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [SEL_W-1:0] ALU_AND  = 4'd2;
  localparam logic [SEL_W-1:0] ALU_OR   = 4'd3;
  localparam logic [SEL_W-1:0] ALU_XOR  = 4'd4;
  localparam logic [SEL_W-1:0] ALU_SLT  = 4'd5;
  localparam logic [SEL_W-1:0] ALU_SLTU = 4'd6;
  localparam logic [SEL_W-1:0] ALU_SLL  = 4'd7;
  localparam logic [SEL_W-1:0] ALU_SRL  = 4'd8;
  localparam logic [SEL_W-1:0] ALU_SRA  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter_2.sv
// Two-input grant logic. ALU_ARB_RR_EN selects round-robin tie-break with a
// last-grant pointer; otherwise requester 0 has fixed priority and no pointer exists.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

`ifdef ALU_ARB_RR_EN
  // High when requester 1 received the most recent grant; resets so requester 0 wins the first tie.
  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (advance) begin
      last_q <= grant[1];
    end
  end

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_ok;

  assign unused_ok = ^{clk, rst_n, advance};
  assign grant     = {req[1] & ~req[0], req[0]};
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Tie-break policy chosen by ALU_ARB_RR_EN (round-robin) or fixed priority when undefined.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic [DATA_W-1:0] req_a_0,
  input  logic [DATA_W-1:0] req_a_1,
  input  logic [DATA_W-1:0] req_b_0,
  input  logic [DATA_W-1:0] req_b_1,
  input  logic [SEL_W-1:0]  req_sel_0,
  input  logic [SEL_W-1:0]  req_sel_1,
  output logic              resp_valid_0,
  output logic              resp_valid_1,
  input  logic              resp_ready_0,
  input  logic              resp_ready_1,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  state_e            state_q, state_d;
  logic [1:0]        req_vec;
  logic [1:0]        grant;
  logic              accept;
  logic              owner_q;
  logic              owner_ready;
  logic [DATA_W-1:0] op_a_p1;
  logic [DATA_W-1:0] op_b_p1;
  logic [SEL_W-1:0]  op_sel_p1;

  assign req_vec     = {req_valid_1, req_valid_0};
  assign accept      = (state_q == IDLE) && (|req_vec);
  assign owner_ready = owner_q ? resp_ready_1 : resp_ready_0;

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_vec),
    .advance (accept),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- stage p1: winner's operation captured on acceptance ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_p1   <= '0;
      op_b_p1   <= '0;
      op_sel_p1 <= ALU_ADD;
      owner_q   <= 1'b0;
    end else if (accept) begin
      op_a_p1   <= grant[1] ? req_a_1   : req_a_0;
      op_b_p1   <= grant[1] ? req_b_1   : req_b_0;
      op_sel_p1 <= grant[1] ? req_sel_1 : req_sel_0;
      owner_q   <= grant[1];
    end
  end

  // ---- stage p2: ALU output captured at the end of EXEC, held through RESP ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_result <= '0;
      resp_zero   <= 1'b0;
    end else if (state_q == EXEC) begin
      resp_result <= alu_result;
      resp_zero   <= alu_zero;
    end
  end

  // req_ready is gated by rst_n so it reads 0 while reset is held even if a requester is valid.
  always_comb begin
    state_d      = state_q;
    req_ready_0  = 1'b0;
    req_ready_1  = 1'b0;
    resp_valid_0 = 1'b0;
    resp_valid_1 = 1'b0;
    alu_a        = '0;
    alu_b        = '0;
    alu_sel      = ALU_ADD;
    unique case (state_q)
      IDLE: begin
        req_ready_0 = rst_n & grant[0];
        req_ready_1 = rst_n & grant[1];
        if (accept) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_a   = op_a_p1;
        alu_b   = op_b_p1;
        alu_sel = op_sel_p1;
        state_d = RESP;
      end
      RESP: begin
        resp_valid_0 = ~owner_q;
        resp_valid_1 = owner_q;
        if (owner_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: models the external ALU and predicts
// grants, latencies and results from the sequencing and arbitration rules.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic         req_ready_0, req_ready_1;
  logic [W-1:0] req_a_0 = '0, req_a_1 = '0, req_b_0 = '0, req_b_1 = '0;
  logic [3:0]   req_sel_0 = '0, req_sel_1 = '0;
  logic         resp_valid_0, resp_valid_1;
  logic         resp_ready_0 = 1'b0, resp_ready_1 = 1'b0;
  logic [W-1:0] resp_result;
  logic         resp_zero;
  logic [W-1:0] alu_a, alu_b;
  logic [3:0]   alu_sel;
  logic [W-1:0] alu_result;
  logic         alu_zero;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] sel);
    case (sel)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLT:  return {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: return {31'd0, (a < b)};
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return W'($signed(a) >>> b[4:0]);
      default:  return ~(a ^ b);
    endcase
  endfunction

  assign alu_result = alu_ref(alu_a, alu_b, alu_sel);
  assign alu_zero   = (alu_result == '0);

  alu_share_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_0  (req_valid_0),
    .req_valid_1  (req_valid_1),
    .req_ready_0  (req_ready_0),
    .req_ready_1  (req_ready_1),
    .req_a_0      (req_a_0),
    .req_a_1      (req_a_1),
    .req_b_0      (req_b_0),
    .req_b_1      (req_b_1),
    .req_sel_0    (req_sel_0),
    .req_sel_1    (req_sel_1),
    .resp_valid_0 (resp_valid_0),
    .resp_valid_1 (resp_valid_1),
    .resp_ready_0 (resp_ready_0),
    .resp_ready_1 (resp_ready_1),
    .resp_result  (resp_result),
    .resp_zero    (resp_zero),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero)
  );

  task automatic set_req(input int k, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [3:0] sel);
    if (k == 0) begin
      req_valid_0 = v; req_a_0 = a; req_b_0 = b; req_sel_0 = sel;
    end else begin
      req_valid_1 = v; req_a_1 = a; req_b_1 = b; req_sel_1 = sel;
    end
  endtask

  // Returns the number of whole cycles waited before req_ready_k was seen, or -1.
  task automatic wait_grant(input int k, input int budget, output int n);
    n = -1;
    for (int i = 0; i < budget; i++) begin
      #1;
      if ((k == 0) ? req_ready_0 : req_ready_1) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_req(0, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)));
    set_req(1, 1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)));
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if ({req_ready_1, req_ready_0, resp_valid_1, resp_valid_0} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_handshake got %b want 0000", {req_ready_1, req_ready_0, resp_valid_1, resp_valid_0});
    end
    vectors++;
    if ({resp_result, resp_zero} !== {32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_resp got %h/%b want 0/0", resp_result, resp_zero);
    end
    vectors++;
    if ({alu_a, alu_b, alu_sel} !== {32'd0, 32'd0, ALU_ADD}) begin
      miscompares++;
      $display("FAIL reset_alu got %h %h %h want 0 0 %h", alu_a, alu_b, alu_sel, ALU_ADD);
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      vectors++;
      if ({req_ready_1, req_ready_0, resp_valid_1, resp_valid_0, alu_a, alu_sel} !== {4'b0000, 32'd0, ALU_ADD}) begin
        miscompares++;
        $display("FAIL post_reset_idle cycle %0d got rdy=%b%b vld=%b%b alu_a=%h sel=%h", i,
                 req_ready_1, req_ready_0, resp_valid_1, resp_valid_0, alu_a, alu_sel);
      end
    end
  endtask

  task automatic test_single();
    int n;
    @(negedge clk);
    resp_ready_0 = 1'b1;
    set_req(0, 1'b1, 32'd5, 32'd3, ALU_SUB);
    wait_grant(0, 10, n);
    vectors++;
    if (n !== 0) begin miscompares++; $display("FAIL single_grant_wait got %0d want 0", n); end
    vectors++;
    if (req_ready_1 !== 1'b0) begin miscompares++; $display("FAIL single_ready_1 got %b want 0", req_ready_1); end
    @(negedge clk);
    set_req(0, 1'b0, $urandom, $urandom, ALU_XOR);
    #1;
    vectors++;
    if ({alu_a, alu_b, alu_sel, resp_valid_0} !== {32'd5, 32'd3, ALU_SUB, 1'b0}) begin
      miscompares++;
      $display("FAIL single_exec got a=%h b=%h sel=%h vld=%b want 5 3 %h 0", alu_a, alu_b, alu_sel, resp_valid_0, ALU_SUB);
    end
    @(negedge clk); #1;
    vectors++;
    if ({resp_valid_1, resp_valid_0, resp_result, resp_zero} !== {2'b01, 32'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL single_resp got vld=%b%b res=%h z=%b want 01 2 0", resp_valid_1, resp_valid_0, resp_result, resp_zero);
    end
    @(negedge clk); #1;
    vectors++;
    if ({resp_valid_0, alu_a, alu_b, alu_sel} !== {1'b0, 32'd0, 32'd0, ALU_ADD}) begin
      miscompares++;
      $display("FAIL single_done got vld=%b alu_a=%h alu_b=%h sel=%h", resp_valid_0, alu_a, alu_b, alu_sel);
    end
  endtask

  task automatic test_tie();
    int n;
    pulse_reset();
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    set_req(0, 1'b1, 32'd7, 32'd7, ALU_SUB);
    set_req(1, 1'b1, 32'd1, 32'd2, ALU_ADD);
    #1;
    vectors++;
    if ({req_ready_1, req_ready_0} !== 2'b01) begin
      miscompares++;
      $display("FAIL tie_first_grant got %b want 01", {req_ready_1, req_ready_0});
    end
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0);
    @(negedge clk); #1;
    vectors++;
    if ({resp_valid_1, resp_valid_0, resp_result, resp_zero, req_ready_1} !== {2'b01, 32'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL tie_resp0 got vld=%b%b res=%h z=%b rdy1=%b want 01 0 1 0", resp_valid_1, resp_valid_0,
               resp_result, resp_zero, req_ready_1);
    end
    @(negedge clk);
    wait_grant(1, 10, n);
    vectors++;
    if (n !== 0) begin miscompares++; $display("FAIL tie_second_grant_wait got %0d want 0", n); end
    @(negedge clk);
    set_req(1, 1'b0, '0, '0, '0);
    @(negedge clk); #1;
    vectors++;
    if ({resp_valid_1, resp_valid_0, resp_result, resp_zero} !== {2'b10, 32'd3, 1'b0}) begin
      miscompares++;
      $display("FAIL tie_resp1 got vld=%b%b res=%h z=%b want 10 3 0", resp_valid_1, resp_valid_0, resp_result, resp_zero);
    end
    @(negedge clk);
  endtask

  // Both requesters stay valid continuously; the model predicts every winner.
  task automatic test_fairness();
    logic [W-1:0] opa[2], opb[2];
    logic [3:0]   ops[2];
    logic [1:0]   exp_g;
    logic [W-1:0] exp_r;
    int           last = 1;
    int           w, grants_1 = 0, exp_grants_1;
    pulse_reset();
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      opa[k] = $urandom; opb[k] = $urandom; ops[k] = 4'($urandom_range(0, 15));
      set_req(k, 1'b1, opa[k], opb[k], ops[k]);
    end
    for (int i = 0; i < 8; i++) begin
      #1;
`ifdef ALU_ARB_RR_EN
      exp_g = (last == 1) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      vectors++;
      if ({req_ready_1, req_ready_0} !== exp_g) begin
        miscompares++;
        $display("FAIL fair_grant op %0d got %b want %b", i, {req_ready_1, req_ready_0}, exp_g);
      end
      w = exp_g[1] ? 1 : 0;
      grants_1 += w;
      last = w;
      exp_r = alu_ref(opa[w], opb[w], ops[w]);
      @(negedge clk);
      opa[w] = $urandom; opb[w] = $urandom; ops[w] = 4'($urandom_range(0, 15));
      set_req(w, 1'b1, opa[w], opb[w], ops[w]);
      @(negedge clk); #1;
      vectors++;
      if ({resp_valid_1, resp_valid_0, resp_result} !== {(w == 1), (w == 0), exp_r}) begin
        miscompares++;
        $display("FAIL fair_resp op %0d got vld=%b%b res=%h want owner %0d res=%h", i, resp_valid_1, resp_valid_0,
                 resp_result, w, exp_r);
      end
      @(negedge clk);
    end
`ifdef ALU_ARB_RR_EN
    exp_grants_1 = 4;
`else
    exp_grants_1 = 0;
`endif
    vectors++;
    if (grants_1 != exp_grants_1) begin
      miscompares++;
      $display("FAIL fair_req1_grants got %0d want %0d", grants_1, exp_grants_1);
    end
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int n;
    logic [W-1:0] a, b, exp_r, exp_r1;
    logic [3:0] s;
    @(negedge clk);
    resp_ready_0 = 1'b0; resp_ready_1 = 1'b1;
    a = $urandom; b = $urandom; s = 4'($urandom_range(0, 9));
    exp_r = alu_ref(a, b, s);
    set_req(0, 1'b1, a, b, s);
    wait_grant(0, 10, n);
    vectors++;
    if (n !== 0) begin miscompares++; $display("FAIL bp_grant_wait got %0d want 0", n); end
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0);
    a = $urandom; b = $urandom; s = 4'($urandom_range(0, 15));
    exp_r1 = alu_ref(a, b, s);
    set_req(1, 1'b1, a, b, s);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      vectors++;
      if ({resp_valid_0, resp_result, resp_zero, req_ready_1} !== {1'b1, exp_r, (exp_r == '0), 1'b0}) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d got vld=%b res=%h z=%b rdy1=%b want 1 %h", i, resp_valid_0,
                 resp_result, resp_zero, req_ready_1, exp_r);
      end
    end
    resp_ready_0 = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if ({resp_valid_0, req_ready_1} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_release got vld0=%b rdy1=%b want 0 1", resp_valid_0, req_ready_1);
    end
    @(negedge clk);
    set_req(1, 1'b0, '0, '0, '0);
    @(negedge clk); #1;
    vectors++;
    if ({resp_valid_1, resp_result} !== {1'b1, exp_r1}) begin
      miscompares++;
      $display("FAIL bp_req1_resp got vld=%b res=%h want 1 %h", resp_valid_1, resp_result, exp_r1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    logic [W-1:0] a, b, exp_r;
    logic [3:0] s;
    @(negedge clk);
    resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
    set_req(0, 1'b1, 32'hdead_beef, 32'h1234_5678, ALU_OR);
    wait_grant(0, 10, n);
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({alu_a, alu_b, alu_sel, resp_result} !== {32'd0, 32'd0, ALU_ADD, 32'd0}) begin
      miscompares++;
      $display("FAIL midrst_async got alu_a=%h alu_b=%h sel=%h res=%h want all reset", alu_a, alu_b, alu_sel, resp_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      vectors++;
      if ({resp_valid_1, resp_valid_0} !== 2'b00) begin
        miscompares++;
        $display("FAIL midrst_no_resp cycle %0d got %b want 00", i, {resp_valid_1, resp_valid_0});
      end
    end
    a = $urandom; b = $urandom; s = 4'($urandom_range(0, 15));
    exp_r = alu_ref(a, b, s);
    @(negedge clk);
    set_req(1, 1'b1, a, b, s);
    wait_grant(1, 10, n);
    vectors++;
    if (n !== 0) begin miscompares++; $display("FAIL midrst_next_grant got %0d want 0", n); end
    @(negedge clk);
    set_req(1, 1'b0, '0, '0, '0);
    @(negedge clk); #1;
    vectors++;
    if ({resp_valid_1, resp_result, resp_zero} !== {1'b1, exp_r, (exp_r == '0)}) begin
      miscompares++;
      $display("FAIL midrst_next_resp got vld=%b res=%h z=%b want 1 %h", resp_valid_1, resp_result, resp_zero, exp_r);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n, prev = -1, gc;
    logic [W-1:0] a, b, exp_r;
    logic [3:0] s;
    @(negedge clk);
    resp_ready_1 = 1'b1;
    a = $urandom; b = $urandom; s = 4'($urandom_range(0, 15));
    set_req(1, 1'b1, a, b, s);
    for (int i = 0; i < 6; i++) begin
      wait_grant(1, 10, n);
      gc = cyc;
      vectors++;
      if (n < 0) begin miscompares++; $display("FAIL b2b_grant_timeout op %0d got %0d want >=0", i, n); end
      if (i > 0) begin
        vectors++;
        if (gc - prev != 3) begin
          miscompares++;
          $display("FAIL b2b_spacing op %0d got %0d want 3", i, gc - prev);
        end
      end
      prev = gc;
      exp_r = alu_ref(a, b, s);
      @(negedge clk);
      a = $urandom; b = $urandom; s = 4'($urandom_range(0, 15));
      set_req(1, 1'b1, a, b, s);
      @(negedge clk); #1;
      vectors++;
      if ({resp_valid_1, resp_result, resp_zero} !== {1'b1, exp_r, (exp_r == '0)}) begin
        miscompares++;
        $display("FAIL b2b_resp op %0d got vld=%b res=%h z=%b want 1 %h", i, resp_valid_1, resp_result, resp_zero, exp_r);
      end
      @(negedge clk);
    end
    set_req(1, 1'b0, '0, '0, '0);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
